// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op codes and constants shared by the arbiter and the ALU core
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_XOR  = 4'd2,
    OP_OR   = 4'd3,
    OP_AND  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } alu_op_e;

  localparam logic [3:0] ALU_OP_LAST = 4'd9;
  localparam int         SHAMT_W     = 5;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// rtl/alu_rr_arbiter_if.sv - request/response bundle between requesters and the shared ALU
interface alu_rr_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [4*NUM_REQ-1:0]  req_op;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_result;
  logic [ID_W-1:0]       rsp_id;
  logic                  rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_id, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_id, rsp_err
  );
endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational RV32I integer ALU; unknown op codes yield 0
module alu_core
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] result
);
  logic [SHAMT_W-1:0] shamt;

  assign shamt = b[SHAMT_W-1:0];

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_XOR:  result = a ^ b;
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = $unsigned($signed(a) >>> shamt);
      OP_SLT:  result = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: result = {31'd0, a < b};
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - round-robin share of one ALU between NUM_REQ requesters,
// with a one-entry tagged response register that allows back-to-back issue
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_rr_arbiter_if.slave  bus
);
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_result_q, rsp_result_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;

  logic                 slot_free;
  logic                 found;
  logic                 accept;
  logic [ID_W-1:0]      win;
  logic [ID_W:0]        pick;
  logic [4*NUM_REQ-1:0] op_vec;
  logic [32*NUM_REQ-1:0] a_vec, b_vec;
  logic [3:0]           sel_op;
  logic [31:0]          sel_a, sel_b, alu_b, alu_result;
  logic                 illegal;

  // Returns {found, index}: first set bit of valid at or after ptr, wrapping.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W:0]    res;
    logic [NUM_REQ-1:0] sh;
    int               idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sh = valid >> idx;
      if (sh[0]) res = {1'b1, idx[ID_W-1:0]};
    end
    return res;
  endfunction

  assign slot_free = !rsp_valid_q || bus.rsp_ready;
  assign pick      = rr_pick(bus.req_valid, rr_ptr_q);
  assign found     = pick[ID_W];
  assign win       = pick[ID_W-1:0];
  // Reset gating keeps req_ready low while rst_n is held, independent of the clock.
  assign accept    = found && slot_free && rst_n;

  assign bus.req_ready = accept ? (NUM_REQ'(1) << win) : '0;

  always_comb begin
    op_vec = bus.req_op >> (4 * int'(win));
    a_vec  = bus.req_a  >> (32 * int'(win));
    b_vec  = bus.req_b  >> (32 * int'(win));
  end

  assign sel_op  = op_vec[3:0];
  assign sel_a   = a_vec[31:0];
  assign sel_b   = b_vec[31:0];
  assign alu_b   = is_shift(sel_op) ? {{(32-SHAMT_W){1'b0}}, sel_b[SHAMT_W-1:0]} : sel_b;
  assign illegal = sel_op > ALU_OP_LAST;

  alu_core u_alu (
    .a      (sel_a),
    .b      (alu_b),
    .op     (sel_op),
    .result (alu_result)
  );

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    rr_ptr_d     = rr_ptr_q;
    if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_result_d = illegal ? 32'd0 : alu_result;
      rsp_id_d     = win;
      rsp_err_d    = illegal;
      rr_ptr_d     = (int'(win) == NUM_REQ - 1) ? '0 : win + ID_W'(1);
    end else if (bus.rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_id_q     <= '0;
      rsp_err_q    <= 1'b0;
      rr_ptr_q     <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_err    = rsp_err_q;
endmodule
